// File: rtl/call_stack_unit.sv
// Return stack of {pc, flags} with configurable overflow policy; pops return on the next cycle (latency 1).
// No backpressure: every push/pop is resolved in the cycle it is sampled, errors are recorded in sticky flags.
module call_stack_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int FLAGS_WIDTH = 4,
    parameter int DEPTH       = 5,
    parameter int OVF_MODE    = 0,
    localparam int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_push,
    input  logic                   in_pop,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic [FLAGS_WIDTH-1:0] in_flags,
    input  logic                   in_clear_err,
    output logic [PC_WIDTH-1:0]    out_ret_pc,
    output logic [FLAGS_WIDTH-1:0] out_ret_flags,
    output logic                   out_ret_valid,
    output logic [PC_WIDTH-1:0]    out_top_pc,
    output logic [LVL_W-1:0]       out_level,
    output logic                   out_empty,
    output logic                   out_full,
    output logic                   out_overflow,
    output logic                   out_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = PC_WIDTH + FLAGS_WIDTH;

    logic [ENT_W-1:0]    mem_q [DEPTH];
    logic [ENT_W-1:0]    mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [ENT_W-1:0]    ret_q, ret_d;
    logic                ret_vld_q, ret_vld_d;
    logic [PC_WIDTH-1:0] top_pc_q, top_pc_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                empty, full, pop_ok, ovf_evt, unf_evt;
    logic [PTR_W-1:0]    top_idx, below_idx;
    logic [ENT_W-1:0]    push_ent;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
    endfunction

    // wr_ptr points at the next free slot; the top entry sits just below it.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        ret_d     = ret_q;
        ret_vld_d = 1'b0;
        top_pc_d  = top_pc_q;
        ovf_evt   = 1'b0;
        unf_evt   = 1'b0;

        empty     = (level_q == '0);
        full      = (level_q == LVL_W'(DEPTH));
        top_idx   = ptr_dec(wr_ptr_q);
        below_idx = ptr_dec(top_idx);
        pop_ok    = in_pop && !empty;
        push_ent  = {in_pc, in_flags};

        if (in_pop && empty) begin
            unf_evt = 1'b1;
        end
        if (pop_ok) begin
            ret_d     = mem_q[top_idx];
            ret_vld_d = 1'b1;
        end

        if (in_push && pop_ok) begin
            mem_d[top_idx] = push_ent;
            top_pc_d       = in_pc;
        end else if (in_push && !full) begin
            mem_d[wr_ptr_q] = push_ent;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            level_d         = level_q + 1'b1;
            top_pc_d        = in_pc;
        end else if (in_push) begin
            ovf_evt = 1'b1;
            // When full, the free-slot pointer aliases the oldest entry.
            if (OVF_MODE == 1) begin
                mem_d[wr_ptr_q] = push_ent;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
                top_pc_d        = in_pc;
            end
        end else if (pop_ok) begin
            wr_ptr_d = top_idx;
            level_d  = level_q - 1'b1;
            top_pc_d = (level_q == LVL_W'(1)) ? '0 : mem_q[below_idx][ENT_W-1:FLAGS_WIDTH];
        end

        ovf_d = ovf_evt || (ovf_q && !in_clear_err);
        unf_d = unf_evt || (unf_q && !in_clear_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            level_q   <= '0;
            ret_q     <= '0;
            ret_vld_q <= 1'b0;
            top_pc_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            ret_q     <= ret_d;
            ret_vld_q <= ret_vld_d;
            top_pc_q  <= top_pc_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign out_ret_pc    = ret_q[ENT_W-1:FLAGS_WIDTH];
    assign out_ret_flags = ret_q[FLAGS_WIDTH-1:0];
    assign out_ret_valid = ret_vld_q;
    assign out_top_pc    = top_pc_q;
    assign out_level     = level_q;
    assign out_empty     = (level_q == '0);
    assign out_full      = (level_q == LVL_W'(DEPTH));
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;

endmodule

// File: tb/tb_call_stack_unit.sv
// Bench for call_stack_unit: reject-mode and circular-mode instances driven in lockstep,
// checked against a vector table, a reference stack model and a return-value scoreboard.
module tb_call_stack_unit;

    localparam int DEPTH = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0, pop = 1'b0, clr = 1'b0;
    logic [7:0] pc = '0;
    logic [3:0] fl = '0;

    logic [7:0] r_pc0, r_pc1, top0, top1;
    logic [3:0] r_fl0, r_fl1;
    logic [2:0] lvl0, lvl1;
    logic       vld0, vld1, emp0, emp1, ful0, ful1, ovf0, ovf1, unf0, unf1;

    call_stack_unit #(.PC_WIDTH(8), .FLAGS_WIDTH(4), .DEPTH(DEPTH), .OVF_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_push(push), .in_pop(pop), .in_pc(pc), .in_flags(fl),
        .in_clear_err(clr), .out_ret_pc(r_pc0), .out_ret_flags(r_fl0), .out_ret_valid(vld0),
        .out_top_pc(top0), .out_level(lvl0), .out_empty(emp0), .out_full(ful0),
        .out_overflow(ovf0), .out_underflow(unf0)
    );

    call_stack_unit #(.PC_WIDTH(8), .FLAGS_WIDTH(4), .DEPTH(DEPTH), .OVF_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_push(push), .in_pop(pop), .in_pc(pc), .in_flags(fl),
        .in_clear_err(clr), .out_ret_pc(r_pc1), .out_ret_flags(r_fl1), .out_ret_valid(vld1),
        .out_top_pc(top1), .out_level(lvl1), .out_empty(emp1), .out_full(ful1),
        .out_overflow(ovf1), .out_underflow(unf1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: index 0 is the oldest entry, sz-1 the top.
    logic [11:0] st [2][DEPTH];
    int          sz [2];
    bit          m_ovf [2], m_unf [2], m_vld [2];
    logic [11:0] m_ret [2];
    logic [11:0] sb0 [$];
    logic [11:0] sb1 [$];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            sz[m] = 0; m_ovf[m] = 0; m_unf[m] = 0; m_vld[m] = 0; m_ret[m] = '0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    task automatic model_step(input int m);
        bit popped = 0;
        bit ovf_e = 0;
        bit unf_e = 0;
        if (pop) begin
            if (sz[m] == 0) unf_e = 1;
            else begin
                sz[m]--;
                popped = 1;
                m_ret[m] = st[m][sz[m]];
                if (m == 0) sb0.push_back(st[m][sz[m]]);
                else        sb1.push_back(st[m][sz[m]]);
            end
        end
        if (push) begin
            if (sz[m] < DEPTH) begin
                st[m][sz[m]] = {pc, fl};
                sz[m]++;
            end else begin
                ovf_e = 1;
                if (m == 1) begin
                    for (int i = 0; i < DEPTH - 1; i++) st[m][i] = st[m][i+1];
                    st[m][DEPTH-1] = {pc, fl};
                end
            end
        end
        m_ovf[m] = ovf_e || (m_ovf[m] && !clr);
        m_unf[m] = unf_e || (m_unf[m] && !clr);
        m_vld[m] = popped;
    endtask

    task automatic check_dut(input int m);
        logic [7:0]  a_top, a_rpc, e_top;
        logic [3:0]  a_rfl;
        logic [2:0]  a_lvl;
        logic        a_vld, a_emp, a_ful, a_ovf, a_unf;
        logic [11:0] e_ret;
        if (m == 0) begin
            a_top = top0; a_rpc = r_pc0; a_rfl = r_fl0; a_lvl = lvl0; a_vld = vld0;
            a_emp = emp0; a_ful = ful0; a_ovf = ovf0; a_unf = unf0;
        end else begin
            a_top = top1; a_rpc = r_pc1; a_rfl = r_fl1; a_lvl = lvl1; a_vld = vld1;
            a_emp = emp1; a_ful = ful1; a_ovf = ovf1; a_unf = unf1;
        end
        e_top = (sz[m] == 0) ? 8'h00 : st[m][sz[m]-1][11:4];
        chk($sformatf("d%0d_level", m), 32'(a_lvl), 32'(sz[m]));
        chk($sformatf("d%0d_top_pc", m), 32'(a_top), 32'(e_top));
        chk($sformatf("d%0d_empty", m), 32'(a_emp), 32'(sz[m] == 0));
        chk($sformatf("d%0d_full", m), 32'(a_ful), 32'(sz[m] == DEPTH));
        chk($sformatf("d%0d_overflow", m), 32'(a_ovf), 32'(m_ovf[m]));
        chk($sformatf("d%0d_underflow", m), 32'(a_unf), 32'(m_unf[m]));
        chk($sformatf("d%0d_ret_valid", m), 32'(a_vld), 32'(m_vld[m]));
        if (a_vld) begin
            if ((m == 0 && sb0.size() == 0) || (m == 1 && sb1.size() == 0)) begin
                n_cmp++;
                n_err++;
                $display("FAIL d%0d_scoreboard: got ret 0x%0h with no pop outstanding", m, {a_rpc, a_rfl});
            end else begin
                e_ret = (m == 0) ? sb0.pop_front() : sb1.pop_front();
                chk($sformatf("d%0d_ret_data", m), 32'({a_rpc, a_rfl}), 32'(e_ret));
            end
        end else begin
            if (m == 0) sb0.delete();
            else        sb1.delete();
            chk($sformatf("d%0d_ret_hold", m), 32'({a_rpc, a_rfl}), 32'(m_ret[m]));
        end
    endtask

    task automatic step(input bit ps, input bit pp, input bit cl, input logic [7:0] p, input logic [3:0] f);
        @(negedge clk);
        push = ps; pop = pp; clr = cl; pc = p; fl = f;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    typedef struct {
        bit         push, pop, clr;
        logic [7:0] pc;
        logic [3:0] fl;
        int         lvl;
        logic [7:0] top;
        bit         vld;
        logic [7:0] ret;
        bit         ovf, unf;
    } vec_t;

    vec_t tbl [29];

    initial begin
        // Expected values for the reject-mode instance.
        tbl[0]  = '{1, 0, 0, 8'h10, 4'h1, 1, 8'h10, 0, 8'h00, 0, 0};
        tbl[1]  = '{1, 0, 0, 8'h20, 4'h2, 2, 8'h20, 0, 8'h00, 0, 0};
        tbl[2]  = '{1, 0, 0, 8'h30, 4'h3, 3, 8'h30, 0, 8'h00, 0, 0};
        tbl[3]  = '{0, 1, 0, 8'h00, 4'h0, 2, 8'h20, 1, 8'h30, 0, 0};
        tbl[4]  = '{0, 1, 0, 8'h00, 4'h0, 1, 8'h10, 1, 8'h20, 0, 0};
        tbl[5]  = '{0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 1, 8'h10, 0, 0};
        tbl[6]  = '{0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 8'h10, 0, 1};
        tbl[7]  = '{0, 1, 1, 8'h00, 4'h0, 0, 8'h00, 0, 8'h10, 0, 1};
        tbl[8]  = '{0, 0, 1, 8'h00, 4'h0, 0, 8'h00, 0, 8'h10, 0, 0};
        tbl[9]  = '{1, 0, 0, 8'h01, 4'h9, 1, 8'h01, 0, 8'h10, 0, 0};
        tbl[10] = '{1, 0, 0, 8'h02, 4'hA, 2, 8'h02, 0, 8'h10, 0, 0};
        tbl[11] = '{1, 0, 0, 8'h03, 4'hB, 3, 8'h03, 0, 8'h10, 0, 0};
        tbl[12] = '{1, 0, 0, 8'h04, 4'hC, 4, 8'h04, 0, 8'h10, 0, 0};
        tbl[13] = '{1, 0, 0, 8'h05, 4'hD, 5, 8'h05, 0, 8'h10, 0, 0};
        tbl[14] = '{1, 0, 0, 8'h06, 4'hE, 5, 8'h05, 0, 8'h10, 1, 0};
        tbl[15] = '{0, 0, 1, 8'h00, 4'h0, 5, 8'h05, 0, 8'h10, 0, 0};
        tbl[16] = '{1, 1, 0, 8'hC0, 4'h7, 5, 8'hC0, 1, 8'h05, 0, 0};
        tbl[17] = '{0, 1, 0, 8'h00, 4'h0, 4, 8'h04, 1, 8'hC0, 0, 0};
        tbl[18] = '{0, 1, 0, 8'h00, 4'h0, 3, 8'h03, 1, 8'h04, 0, 0};
        tbl[19] = '{0, 1, 0, 8'h00, 4'h0, 2, 8'h02, 1, 8'h03, 0, 0};
        tbl[20] = '{0, 1, 0, 8'h00, 4'h0, 1, 8'h01, 1, 8'h02, 0, 0};
        tbl[21] = '{0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 1, 8'h01, 0, 0};
        tbl[22] = '{1, 0, 0, 8'hA0, 4'h4, 1, 8'hA0, 0, 8'h01, 0, 0};
        tbl[23] = '{1, 0, 0, 8'hB0, 4'h5, 2, 8'hB0, 0, 8'h01, 0, 0};
        tbl[24] = '{1, 1, 0, 8'hC0, 4'h6, 2, 8'hC0, 1, 8'hB0, 0, 0};
        tbl[25] = '{0, 1, 0, 8'h00, 4'h0, 1, 8'hA0, 1, 8'hC0, 0, 0};
        tbl[26] = '{0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 1, 8'hA0, 0, 0};
        tbl[27] = '{1, 1, 0, 8'h55, 4'h8, 1, 8'h55, 0, 8'hA0, 0, 1};
        tbl[28] = '{0, 1, 1, 8'h00, 4'h0, 0, 8'h00, 1, 8'h55, 0, 0};

        model_reset();
        #12;
        chk("reset_ret_pc", 32'(r_pc0), 32'h0);
        chk("reset_ret_flags", 32'(r_fl0), 32'h0);
        chk("reset_ret_valid", 32'(vld0), 32'h0);
        chk("reset_top_pc", 32'(top0), 32'h0);
        chk("reset_level", 32'(lvl0), 32'h0);
        chk("reset_empty", 32'(emp0), 32'h1);
        chk("reset_full", 32'(ful0), 32'h0);
        chk("reset_flags", 32'({ovf0, unf0, ovf1, unf1}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].pc, tbl[i].fl);
            chk($sformatf("vec%0d_level", i), 32'(lvl0), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_top_pc", i), 32'(top0), 32'(tbl[i].top));
            chk($sformatf("vec%0d_ret_valid", i), 32'(vld0), 32'(tbl[i].vld));
            chk($sformatf("vec%0d_ret_pc", i), 32'(r_pc0), 32'(tbl[i].ret));
            chk($sformatf("vec%0d_overflow", i), 32'(ovf0), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d_underflow", i), 32'(unf0), 32'(tbl[i].unf));
        end

        // Circular overflow: seven pushes keep only the newest five.
        for (int i = 1; i <= 7; i++) step(1, 0, 0, 8'(i), 4'(i));
        chk("circ_level", 32'(lvl1), 32'd5);
        chk("circ_overflow", 32'(ovf1), 32'h1);
        chk("circ_top", 32'(top1), 32'h07);
        chk("rej_top", 32'(top0), 32'h05);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'h00, 4'h0);
            chk($sformatf("circ_pop%0d", i), 32'(r_pc1), 32'(7 - i));
            chk($sformatf("rej_pop%0d", i), 32'(r_pc0), 32'(5 - i));
        end
        step(0, 0, 1, 8'h00, 4'h0);

        // Asynchronous reset between edges while a pop is being presented.
        step(1, 0, 0, 8'h40, 4'h4);
        @(negedge clk);
        push = 1'b0; pop = 1'b1; clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ret_pc", 32'(r_pc0), 32'h0);
        chk("arst_ret_valid", 32'(vld0), 32'h0);
        chk("arst_top_pc", 32'(top0), 32'h0);
        chk("arst_level", 32'(lvl0), 32'h0);
        chk("arst_empty", 32'(emp0), 32'h1);
        chk("arst_ovf1_level", 32'({ovf1, unf1, lvl1}), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        pop = 1'b0;
        rst_n = 1'b1;
        step(0, 1, 0, 8'h00, 4'h0);
        chk("post_reset_underflow", 32'(unf0), 32'h1);
        chk("post_reset_no_valid", 32'(vld0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
